inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, first fetch address after reset.
REQ-002 Parameter: NOP_INST, 16'h4300, value driven on ir_inst when no instruction is buffered.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset; the ports SHALL be exactly as listed in REQ-004 to REQ-016.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 resetn  in  1  synchronous active-low reset.
REQ-006 imem_req  out  1  fetch request to instruction memory.
REQ-007 imem_addr  out  16  byte address of request, halfword aligned.
REQ-008 imem_ack  in  1  memory accepts request and returns data in the same cycle.
REQ-009 imem_rdata  in  16  fetched instruction, valid when imem_ack=1.
REQ-010 branch_taken  in  1  redirect pulse from execute.
REQ-011 branch_target  in  16  redirect address, valid with branch_taken.
REQ-012 stall  in  1  downstream instruction register cannot load this cycle.
REQ-013 ir_wen  out  1  load strobe to instruction register.
REQ-014 ir_inst  out  16  instruction presented to instruction register.
REQ-015 ir_pc  out  16  address of ir_inst.
REQ-016 buf_count  out  2  prefetch buffer occupancy, 0..2.

Function
REQ-017 Internal state: fetch_pc (next address to request); a request-address register driving imem_addr; a 2-entry FIFO of {inst, pc}; and an FSM with states IDLE, WAIT and DROP.
REQ-018 IDLE: if buf_count < 2 and branch_taken=0, set imem_req=1 and imem_addr=fetch_pc on the next edge, then go to WAIT; otherwise stay in IDLE with imem_req=0.
REQ-019 WAIT: imem_req and imem_addr SHALL hold stable until the cycle in which imem_ack=1.
REQ-020 WAIT with imem_ack=1 and branch_taken=0: push {imem_rdata, imem_addr} and set fetch_pc = fetch_pc + 2 (modulo 2^16, wraps 16'hFFFE to 16'h0000).
REQ-021 After the push in REQ-020: if the post-cycle occupancy (count + 1 - pop) < 2, stay in WAIT with imem_addr = the new fetch_pc (back-to-back issue); else go to IDLE with imem_req=0.
REQ-022 WAIT with branch_taken=1 and imem_ack=0: go to DROP, keep imem_req/imem_addr unchanged, and set fetch_pc = branch_target.
REQ-023 WAIT with branch_taken=1 and imem_ack=1: discard the returned data, set fetch_pc = branch_target, and go to IDLE with imem_req=0.
REQ-024 DROP: keep the request stable; on imem_ack, discard the data and go to IDLE; a further branch_taken updates fetch_pc to the latest branch_target.
REQ-025 At most one request SHALL be outstanding; a new request is never issued in the ack cycle of a dropped one.
REQ-026 Delivery: ir_wen = (buf_count != 0) & ~stall & ~branch_taken; ir_inst/ir_pc = FIFO head; the head is popped in the same cycle as ir_wen.
REQ-027 When buf_count = 0: ir_inst = NOP_INST and ir_pc = fetch_pc.
REQ-028 Latency: data accepted at ack edge N is presented with ir_wen in cycle N+1 at the earliest; no combinational path from imem_rdata to ir_inst.
REQ-029 branch_taken SHALL flush the FIFO (buf_count = 0 next cycle), overriding any same-cycle push or pop.
REQ-030 A full FIFO with a pop in the same cycle as an ack SHALL NOT occur by REQ-018/REQ-021, and the FIFO SHALL never overflow or underflow.
REQ-031 Order: instructions SHALL reach ir_inst in fetch-address order, with none skipped or duplicated between redirects.

Reset
REQ-032 While resetn=0 at a clock edge: state=IDLE, fetch_pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, FIFO empty, buf_count=0, ir_wen=0, ir_inst=NOP_INST, ir_pc=RESET_PC.
REQ-033 Reset asserted mid-request (WAIT or DROP) SHALL abandon the request; an imem_ack arriving in the same cycle is ignored.
REQ-034 The first imem_req=1 SHALL appear one cycle after the first edge with resetn=1.

Verification
REQ-035 Reset release, memory acks every cycle, stall=0 -> imem_addr sequence 0000,0002,0004,...; ir_wen=1 from the cycle after the first ack; ir_inst follows memory contents in order.
REQ-036 stall=1 held for 5 cycles -> buf_count reaches 2, imem_req=0; after stall drops, the two buffered instructions are delivered in order, then fetch resumes at 0x0004-relative next address.
REQ-037 branch_taken with target 0x0100 while WAIT on 0x0006 and ack delayed 3 cycles -> imem_addr holds 0x0006 until ack, data dropped, next request 0x0100, first ir_inst has ir_pc=0x0100.
REQ-038 branch_taken in the same cycle as ack -> no ir_wen that cycle, ack data discarded, buf_count=0, next request to branch_target.
REQ-039 fetch_pc=16'hFFFE with ack -> next imem_addr=16'h0000.
REQ-040 resetn=0 during WAIT with a concurrent ack -> next cycle imem_req=0, buf_count=0, ir_inst=16'h4300.

Source files
------------

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch
//  Purpose  : Instruction fetch unit. It issues halfword-aligned requests to
//             the instruction memory, holds at most one request outstanding,
//             buffers up to two returned instructions in a prefetch FIFO and
//             delivers them in address order to the instruction register.
//             A branch redirect flushes the FIFO. If a request is in flight
//             when the branch arrives, that request is completed and its
//             data dropped.
//  Ports    : clk, resetn        - clock, synchronous active-low reset
//             imem_req/addr      - memory request, address held until ack
//             imem_ack/rdata     - same-cycle accept + read data
//             branch_taken/target- redirect from execute
//             stall              - instruction register cannot load
//             ir_wen/inst/pc     - delivery to instruction register
//             buf_count          - prefetch FIFO occupancy (0..2)
//  Revision : 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h4300
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        stall,
    output logic        ir_wen,
    output logic [15:0] ir_inst,
    output logic [15:0] ir_pc,
    output logic [1:0]  buf_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] fetch_pc_q, fetch_pc_d;
    logic [15:0] addr_q, addr_d;
    logic        req_q, req_d;

    // Two-entry FIFO. Entry 0 is always the head; a pop shifts entry 1 down.
    logic [15:0] inst0_q, inst0_d, pc0_q, pc0_d;
    logic [15:0] inst1_q, inst1_d, pc1_q, pc1_d;
    logic [1:0]  count_q, count_d;

    logic        w_pop;
    logic        w_push;
    logic [15:0] w_pc_inc;
    logic [2:0]  w_occ_after;

    assign w_pop       = (count_q != 2'd0) & ~stall & ~branch_taken;
    assign w_pc_inc    = fetch_pc_q + 16'd2;
    // Occupancy after this cycle's push and pop. It decides whether the next
    // request can be issued back-to-back.
    assign w_occ_after = {1'b0, count_q} + 3'd1 - {2'b00, w_pop};

    // ------------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        w_push     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if ((count_q < 2'd2) && !branch_taken) begin
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ack && !branch_taken) begin
                    w_push     = 1'b1;
                    fetch_pc_d = w_pc_inc;
                    if (w_occ_after < 3'd2) begin
                        addr_d = w_pc_inc;
                    end else begin
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end else if (branch_taken && !imem_ack) begin
                    // The memory still owes us a response. Keep the request
                    // stable and discard the data when it arrives.
                    state_d = S_DROP;
                end else if (branch_taken && imem_ack) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_DROP: begin
                // Going to IDLE, not re-issuing, keeps a new request out of
                // the ack cycle of the dropped one.
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Only the latest redirect target counts, whatever the state.
        if (branch_taken) begin
            fetch_pc_d = branch_target;
        end
    end

    // ------------------------------------------------------------------------
    // Prefetch FIFO
    // ------------------------------------------------------------------------
    always_comb begin
        inst0_d = inst0_q;
        pc0_d   = pc0_q;
        inst1_d = inst1_q;
        pc1_d   = pc1_q;
        count_d = count_q;

        if (branch_taken) begin
            count_d = 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        inst0_d = imem_rdata;
                        pc0_d   = addr_q;
                    end else begin
                        inst1_d = imem_rdata;
                        pc1_d   = addr_q;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    inst0_d = inst1_q;
                    pc0_d   = pc1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        inst0_d = imem_rdata;
                        pc0_d   = addr_q;
                    end else begin
                        inst0_d = inst1_q;
                        pc0_d   = pc1_q;
                        inst1_d = imem_rdata;
                        pc1_d   = addr_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            count_q    <= 2'd0;
            inst0_q    <= NOP_INST;
            pc0_q      <= RESET_PC;
            inst1_q    <= NOP_INST;
            pc1_q      <= RESET_PC;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            inst0_q    <= inst0_d;
            pc0_q      <= pc0_d;
            inst1_q    <= inst1_d;
            pc1_q      <= pc1_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. Delivery comes only from registered FIFO entries, so there is
    // no path from imem_rdata to ir_inst.
    // ------------------------------------------------------------------------
    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign ir_wen    = w_pop;
    assign ir_inst   = (count_q != 2'd0) ? inst0_q : NOP_INST;
    assign ir_pc     = (count_q != 2'd0) ? pc0_q : fetch_pc_q;
    assign buf_count = count_q;

endmodule
`default_nettype wire
